// File: rtl/prog_loader_if.sv
// Byte-stream receive handshake plus the debug write bus toward cpuCore.
// The host side drives bytes in and observes the word writes.
interface prog_loader_if #(
  parameter int XLEN = 32
);
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            rx_ready;
  logic            dbg_wr_en;
  logic [XLEN-1:0] dbg_addr;
  logic [XLEN-1:0] dbg_instr;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  dbg_wr_en,
    input  dbg_addr,
    input  dbg_instr
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output dbg_wr_en,
    output dbg_addr,
    output dbg_instr
  );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream boot loader: assembles little-endian words, writes
// them through the debug port and releases the core on a good checksum.
module prog_loader #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] BASE_ADDR = '0,
  parameter int              MAX_WORDS = 256,
  parameter logic [7:0]      SYNC_BYTE = 8'hA5
) (
  input  logic           clk,
  input  logic           rst,
  prog_loader_if.slave   bus,
  input  logic           reload,
  output logic           cpu_rst,
  output logic           done,
  output logic           error
);

  localparam int NB = XLEN / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, nxt;

  logic [7:0]      len_lo;
  logic [15:0]     len;
  logic [15:0]     word_k;
  logic [BW-1:0]   byte_idx;
  logic [7:0]      csum;
  logic [XLEN-1:0] wbuf;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] addr_q;
  logic            wr_en_q;
  logic            rdy;

  logic            fire;
  logic [15:0]     len_n;
  logic            last_byte;
  logic            last_word;
  logic [XLEN-1:0] word_nxt;
  logic [XLEN+7:0] shifted;

  assign fire      = bus.rx_valid && bus.rx_ready;
  assign len_n     = {bus.rx_data, len_lo};
  assign last_byte = byte_idx == BW'(NB - 1);
  assign last_word = ({1'b0, word_k} + 17'd1) >= {1'b0, len};
  assign shifted   = {bus.rx_data, wbuf} >> 8;
  assign word_nxt  = shifted[XLEN-1:0];

  // Ready is forced low while reset is held, independent of the state.
  always_comb begin
    rdy = 1'b0;
    unique case (state)
      S_SYNC, S_LEN0, S_LEN1,
      S_DATA, S_CSUM: rdy = 1'b1;
      default:        rdy = 1'b0;
    endcase
  end

  assign bus.rx_ready  = rst && rdy;
  assign bus.dbg_wr_en = wr_en_q;
  assign bus.dbg_addr  = addr_q;
  assign bus.dbg_instr = instr_q;

  always_comb begin
    nxt = state;
    unique case (state)
      S_SYNC:
        if (fire && bus.rx_data == SYNC_BYTE) nxt = S_LEN0;
      S_LEN0:
        if (fire) nxt = S_LEN1;
      S_LEN1:
        if (fire) begin
          if (len_n == 16'd0)              nxt = S_CSUM;
          else if ({1'b0, len_n} > MAX_W)  nxt = S_ERR;
          else                             nxt = S_DATA;
        end
      S_DATA:
        if (fire && last_byte) nxt = S_WRITE;
      S_WRITE:
        nxt = last_word ? S_CSUM : S_DATA;
      S_CSUM:
        if (fire) nxt = (bus.rx_data == csum) ? S_DONE : S_ERR;
      S_DONE, S_ERR:
        if (reload) nxt = S_SYNC;
      default:
        nxt = S_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_SYNC;
    else      state <= nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_lo   <= '0;
      len      <= '0;
      word_k   <= '0;
      byte_idx <= '0;
      csum     <= '0;
      wbuf     <= '0;
      instr_q  <= '0;
      addr_q   <= BASE_ADDR;
      wr_en_q  <= 1'b0;
      cpu_rst  <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      wr_en_q <= nxt == S_WRITE;
      done    <= nxt == S_DONE;
      error   <= nxt == S_ERR;
      cpu_rst <= nxt != S_DONE;
      unique case (state)
        S_SYNC:
          if (fire && bus.rx_data == SYNC_BYTE) begin
            csum     <= '0;
            byte_idx <= '0;
            word_k   <= '0;
            len      <= '0;
          end
        S_LEN0:
          if (fire) len_lo <= bus.rx_data;
        S_LEN1:
          if (fire) len <= len_n;
        S_DATA:
          if (fire) begin
            wbuf <= word_nxt;
            csum <= csum ^ bus.rx_data;
            if (last_byte) begin
              byte_idx <= '0;
              instr_q  <= word_nxt;
              addr_q   <= BASE_ADDR
                        + XLEN'(word_k) * XLEN'(NB);
            end else begin
              byte_idx <= byte_idx + BW'(1);
            end
          end
        S_WRITE:
          word_k <= word_k + 16'd1;
        S_DONE, S_ERR:
          if (reload) begin
            csum     <= '0;
            byte_idx <= '0;
            word_k   <= '0;
            len      <= '0;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized frame stimulus with a write scoreboard and an outcome model
// derived from the frame contents.
module tb_prog_loader;

  localparam int XLEN = 32;
  localparam int MAXW = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic reload = 1'b0;
  logic cpu_rst, done, error;

  prog_loader_if #(.XLEN(XLEN)) bus ();

  prog_loader #(
    .XLEN(XLEN),
    .BASE_ADDR('0),
    .MAX_WORDS(MAXW),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .reload(reload),
    .cpu_rst(cpu_rst),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } wr_t;

  int checks = 0;
  int errors = 0;
  wr_t exp_q[$];
  wr_t got;
  logic [7:0] fb[$];
  logic [31:0] wq[$];
  bit exp_ok;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst && bus.dbg_wr_en === 1'b1) begin
      chk("ready_in_write", 64'(bus.rx_ready), 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(bus.dbg_addr), 64'hFFFF_FFFF_FFFF);
      end else begin
        got = exp_q.pop_front();
        chk("wr_addr", 64'(bus.dbg_addr), 64'(got.addr));
        chk("wr_instr", 64'(bus.dbg_instr), 64'(got.instr));
      end
    end
  end

  // Reference: frame bytes, expected writes and outcome from the word list.
  task automatic make_frame(input bit bad);
    logic [7:0] cs;
    logic [31:0] w;
    int n;
    n = wq.size();
    cs = 8'h00;
    fb.delete();
    fb.push_back(8'hA5);
    fb.push_back(8'(n));
    fb.push_back(8'(n >> 8));
    for (int k = 0; k < n; k++) begin
      w = wq[k];
      for (int i = 0; i < 4; i++) begin
        fb.push_back(w[8*i +: 8]);
        cs = cs ^ w[8*i +: 8];
      end
      exp_q.push_back('{addr: 32'(k * 4), instr: w});
    end
    fb.push_back(bad ? (cs ^ 8'h01) : cs);
    exp_ok = !bad;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 3)) @(posedge clk);
    if (gaps) #1;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (bus.rx_ready !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 50) begin
        chk("ready_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic send_frame(input bit gaps);
    foreach (fb[i]) send_byte(fb[i], gaps);
  endtask

  task automatic check_outcome(input string tag);
    chk({tag, "_done"}, 64'(done), 64'(exp_ok));
    chk({tag, "_error"}, 64'(error), 64'(!exp_ok));
    chk({tag, "_cpu_rst"}, 64'(cpu_rst), 64'(!exp_ok));
    chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    chk("reload_done", 64'(done), 64'd0);
    chk("reload_error", 64'(error), 64'd0);
    chk("reload_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("reload_ready", 64'(bus.rx_ready), 64'd1);
  endtask

  task automatic nominal_words();
    wq.delete();
    wq.push_back(32'h00C00093);
    wq.push_back(32'h00200113);
    wq.push_back(32'h0000D663);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(bus.rx_ready), 64'd0);
    chk({tag, "_wr_en"}, 64'(bus.dbg_wr_en), 64'd0);
    chk({tag, "_addr"}, 64'(bus.dbg_addr), 64'd0);
    chk({tag, "_instr"}, 64'(bus.dbg_instr), 64'd0);
    chk({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd1);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
  endtask

  initial begin
    logic [7:0] g;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    #12;
    check_reset_vals("rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("post_rst_ready", 64'(bus.rx_ready), 64'd1);
    @(posedge clk);
    #1;

    nominal_words();
    make_frame(1'b0);
    send_frame(1'b0);
    check_outcome("nominal");
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold", 64'(done), 64'd1);
    chk("done_ready", 64'(bus.rx_ready), 64'd0);
    do_reload();

    nominal_words();
    make_frame(1'b1);
    send_frame(1'b0);
    check_outcome("badcsum");
    do_reload();

    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("toolong_error", 64'(error), 64'd1);
    chk("toolong_done", 64'(done), 64'd0);
    chk("toolong_cpu_rst", 64'(cpu_rst), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    do_reload();

    wq.delete();
    make_frame(1'b0);
    send_frame(1'b0);
    check_outcome("len0");
    do_reload();

    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    nominal_words();
    make_frame(1'b0);
    send_frame(1'b1);
    check_outcome("garbage");
    do_reload();

    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(0, 3)) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g, 1'b1);
      end
      wq.delete();
      repeat ($urandom_range(1, 6)) wq.push_back($urandom);
      make_frame(($urandom % 3) == 0);
      send_frame(1'b1);
      check_outcome("random");
      do_reload();
    end

    nominal_words();
    make_frame(1'b0);
    for (int i = 0; i < 5; i++) send_byte(fb[i], 1'b0);
    rst = 1'b0;
    #2;
    check_reset_vals("midrst");
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    nominal_words();
    make_frame(1'b0);
    send_frame(1'b1);
    check_outcome("after_rst");

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
